layered_spi_control: RTL and testbench
======================================

Name: layered_spi_control

Overview:
- SPI-slave control register file for an N-layer compositing pipeline.
- Generalises single-foreground control to LAYER_COUNT foreground layers. Adds clipping registers, shadow/active double-buffering and frame-synchronous commit.
- Sits between the host SPI bus and the pipeline ctrl_* inputs. All logic runs in the pixel clock domain.

Parameters:
- PRECISION, 11, coordinate width. Must be ≤ 15.
- LAYER_COUNT, 2, number of foreground layers. Range 1..8.
- SYNC_STAGES, 2, synchroniser depth on the SPI inputs.

Ports:
- clk  in  1  pixel clock. Must be ≥ 8× hw_spi_clk.
- rst  in  1  reset; synchronous, active-high.
- frame_start  in  1  one-cycle pulse at the first pixel of a frame.
- hw_spi_clk  in  1  SPI SCLK, mode 0.
- hw_spi_ss  in  1  SPI select, active-low.
- hw_spi_mosi  in  1  SPI data in, MSB first.
- hw_spi_miso  out  1  SPI data out.
- ctrl_overlay_mode  out  2*LAYER_COUNT  active mode per layer. Layer i occupies bits [2i+1:2i].
- ctrl_fg_scale  out  2*LAYER_COUNT  active scale per layer.
- ctrl_fg_offset_x  out  (PRECISION+1)*LAYER_COUNT  active signed X offset per layer.
- ctrl_fg_offset_y  out  (PRECISION+1)*LAYER_COUNT  active signed Y offset per layer.
- ctrl_fg_clip_left, ctrl_fg_clip_right, ctrl_fg_clip_top, ctrl_fg_clip_bottom  out  PRECISION*LAYER_COUNT each  active clip values per layer.
- commit_done  out  1  one-cycle pulse when shadow is copied to active.

Behaviour:
- Inputs: SCLK, SS and MOSI each pass through SYNC_STAGES flops. Edges are detected on synchronised SCLK. MOSI is sampled on the rising edge.
- Frame protocol: SS low, then 24 bits.
  - Byte 0 = {wr, layer[2:0], reg[3:0]}.
  - Bytes 1-2 = 16-bit value, big-endian.
- Framer states:
  - IDLE: SS high; bit counter = 0.
  - SHIFT: SS low, counting bits 0..23.
  - EXEC: one cycle after bit 23, performs the write.
  - DRAIN: further bits until SS rises; they are ignored.
- Framer transitions:
  - SS rising in any state → IDLE. A partial frame is discarded with no register change.
  - rst in any state → IDLE, discarding any partial frame.
- Register map (per layer, shadow set). The value is truncated to field width; offsets keep the low PRECISION+1 bits, two's complement.
  - 0 mode[1:0]
  - 1 scale[1:0]
  - 2 offset_x
  - 3 offset_y
  - 4 clip_left
  - 5 clip_right
  - 6 clip_top
  - 7 clip_bottom
  - 15 commit request; value and layer are ignored. It sets commit_pending.
  - Regs 8-14 are ignored.
- Writes with layer ≥ LAYER_COUNT are ignored. This includes reg 15.
- Commit rules:
  - On frame_start with commit_pending=1: all shadow copied to active in one cycle, commit_pending cleared, commit_done=1 for that cycle.
  - On frame_start with commit_pending=0: no change.
- Same-cycle EXEC and frame_start:
  - Active receives the shadow value before the write; the write lands in shadow.
  - A reg-15 EXEC on the same cycle as frame_start leaves commit_pending=1, so it commits on the next frame.
- Latency:
  - Shadow updates 1 cycle after the synchronised 24th rising SCLK edge.
  - Outputs change only on the cycle after a committing frame_start.
- Reset values: all shadow, active and ctrl_* outputs = 0; commit_pending=0; commit_done=0; hw_spi_miso=0; framer=IDLE.

Optional Feature:
- CTRL_READBACK_EN defined:
  - Frames with wr=0 are reads.
  - During byte 0, MISO shifts the status byte {commit_pending, 7'b0}.
  - During bytes 1-2, MISO shifts the addressed shadow register, MSB first.
    - Offsets are sign-extended to 16 bits; other fields are zero-extended.
    - Invalid layer or reg reads as 0x0000.
  - MISO updates on the synchronised SCLK falling edge.
  - The first bit is presented when SS falls.
- CTRL_READBACK_EN undefined:
  - hw_spi_miso is constant 0.
  - wr=0 frames have no effect.

Test Plan:
- rst=1 for 2 cycles → every ctrl_* output = 0, commit_done=0, hw_spi_miso=0.
- Write 0xAA,0xFF,0xFB (layer2 reg10 invalid, LAYER_COUNT=2) then 0x92,0xFF,0xFB (layer1 offset_x=-5), then 0x8F,0x00,0x00, then frame_start → ctrl_fg_offset_x[23:12]=12'hFFB; layer0 field unchanged at 0; commit_done pulses once.
- Write layer0 clip_left=0x0010 and commit, but no frame_start → ctrl_fg_clip_left stays 0. On the next frame_start it becomes 0x010.
- Raise SS after 13 bits of a write to layer0 mode → shadow and active unchanged. An immediately following full frame 0x80,0x00,0x02 plus commit gives ctrl_overlay_mode[1:0]=2.
- Time commit EXEC to coincide with frame_start → no commit_done that frame; commit_done on the following frame_start.
- (CTRL_READBACK_EN) Write layer1 offset_y=-3, then read 0x13,0x00,0x00 → MISO = status 0x80 if uncommitted, then 0xFFFD.

Source files
------------

// File: rtl/layered_spi_control.sv
// layered_spi_control: SPI-slave (mode 0) control register file for an
// N-layer compositing pipeline. Host writes land in a shadow register set;
// a commit request copies shadow to active on the next frame_start.
// Optional feature macro: CTRL_READBACK_EN (shadow readback on MISO).
// All logic runs in the pixel clock domain; SPI inputs are synchronised.
module layered_spi_control #(
    parameter int PRECISION   = 11,
    parameter int LAYER_COUNT = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 frame_start,
    input  logic                                 hw_spi_clk,
    input  logic                                 hw_spi_ss,
    input  logic                                 hw_spi_mosi,
    output logic                                 hw_spi_miso,
    output logic [2*LAYER_COUNT-1:0]             ctrl_overlay_mode,
    output logic [2*LAYER_COUNT-1:0]             ctrl_fg_scale,
    output logic [(PRECISION+1)*LAYER_COUNT-1:0] ctrl_fg_offset_x,
    output logic [(PRECISION+1)*LAYER_COUNT-1:0] ctrl_fg_offset_y,
    output logic [PRECISION*LAYER_COUNT-1:0]     ctrl_fg_clip_left,
    output logic [PRECISION*LAYER_COUNT-1:0]     ctrl_fg_clip_right,
    output logic [PRECISION*LAYER_COUNT-1:0]     ctrl_fg_clip_top,
    output logic [PRECISION*LAYER_COUNT-1:0]     ctrl_fg_clip_bottom,
    output logic                                 commit_done
);

    // One layer's worth of control fields.
    typedef struct packed {
        logic [1:0]           mode;
        logic [1:0]           scale;
        logic [PRECISION:0]   off_x;
        logic [PRECISION:0]   off_y;
        logic [PRECISION-1:0] clip_left;
        logic [PRECISION-1:0] clip_right;
        logic [PRECISION-1:0] clip_top;
        logic [PRECISION-1:0] clip_bottom;
    } layer_regs_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_EXEC,
        S_DRAIN
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'd23;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   sclk_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   sclk_rise;

    // Shift the raw SPI pins through SYNC_STAGES flops; remember last SCLK.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(hw_spi_clk);
            ss_sync   <= (ss_sync << 1)   | SYNC_STAGES'(hw_spi_ss);
            mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(hw_spi_mosi);
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;

    // ------------------------------------------------------------------
    // Framer FSM
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_next;
    logic [4:0]  bit_cnt;
    logic [23:0] shift_reg;
    logic        shift_en;
    logic        exec_en;
    logic        cnt_clear;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: SS high always returns to IDLE, dropping partial frames.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        if (ss_s) begin
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  state_next = S_SHIFT;
                S_SHIFT: if (sclk_rise && bit_cnt == LAST_BIT) state_next = S_EXEC;
                S_EXEC:  state_next = S_DRAIN;
                S_DRAIN: state_next = S_DRAIN;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Output decode of the framer state.
    always_comb begin
        shift_en  = (state == S_SHIFT) && sclk_rise;
        exec_en   = (state == S_EXEC);
        cnt_clear = (state != S_SHIFT);
    end

    // Bit counter and MOSI shift register, sampled on synchronised SCLK rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (cnt_clear) begin
            bit_cnt   <= '0;
        end else if (shift_en) begin
            bit_cnt   <= bit_cnt + 5'd1;
            shift_reg <= {shift_reg[22:0], mosi_s};
        end
    end

    // ------------------------------------------------------------------
    // Frame decode
    // ------------------------------------------------------------------
    logic        fr_wr;
    logic [2:0]  fr_layer;
    logic [3:0]  fr_reg;
    logic [15:0] fr_value;
    logic        fr_layer_ok;
    logic        do_write;
    logic        do_commit_req;
    logic        unused_value_bits;

    assign fr_wr         = shift_reg[23];
    assign fr_layer      = shift_reg[22:20];
    assign fr_reg        = shift_reg[19:16];
    assign fr_value      = shift_reg[15:0];
    assign fr_layer_ok   = int'(fr_layer) < LAYER_COUNT;
    assign do_write      = exec_en && fr_wr && fr_layer_ok && (fr_reg <= 4'd7);
    assign do_commit_req = exec_en && fr_wr && fr_layer_ok && (fr_reg == 4'hF);
    // Upper value bits are simply truncated away for the narrow fields.
    assign unused_value_bits = ^fr_value;

    // ------------------------------------------------------------------
    // Shadow / active register sets and frame-synchronous commit
    // ------------------------------------------------------------------
    layer_regs_t shadow [LAYER_COUNT];
    layer_regs_t active [LAYER_COUNT];
    logic        commit_pending;
    logic        commit_now;

    assign commit_now = frame_start && commit_pending;

    // Shadow writes from EXEC; commit copies the pre-write shadow to active.
    always_ff @(posedge clk) begin
        // NOTE: the register arrays are reset explicitly; they are small flop
        // banks feeding the pipeline, not RAM, and must come up as zero.
        if (rst) begin
            for (int i = 0; i < LAYER_COUNT; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
        end else begin
            commit_done <= commit_now;
            if (commit_now) begin
                for (int i = 0; i < LAYER_COUNT; i++) begin
                    active[i] <= shadow[i];
                end
            end
            // A request arriving with frame_start survives to the next frame.
            if (do_commit_req) begin
                commit_pending <= 1'b1;
            end else if (frame_start) begin
                commit_pending <= 1'b0;
            end
            if (do_write) begin
                for (int i = 0; i < LAYER_COUNT; i++) begin
                    if (int'(fr_layer) == i) begin
                        case (fr_reg)
                            4'd0: shadow[i].mode        <= fr_value[1:0];
                            4'd1: shadow[i].scale       <= fr_value[1:0];
                            4'd2: shadow[i].off_x       <= fr_value[PRECISION:0];
                            4'd3: shadow[i].off_y       <= fr_value[PRECISION:0];
                            4'd4: shadow[i].clip_left   <= fr_value[PRECISION-1:0];
                            4'd5: shadow[i].clip_right  <= fr_value[PRECISION-1:0];
                            4'd6: shadow[i].clip_top    <= fr_value[PRECISION-1:0];
                            4'd7: shadow[i].clip_bottom <= fr_value[PRECISION-1:0];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Pack the active set onto the flat ctrl_* buses, layer i at slice i.
    for (genvar g = 0; g < LAYER_COUNT; g++) begin : g_pack
        assign ctrl_overlay_mode[2*g +: 2]                 = active[g].mode;
        assign ctrl_fg_scale[2*g +: 2]                     = active[g].scale;
        assign ctrl_fg_offset_x[(PRECISION+1)*g +: PRECISION+1] = active[g].off_x;
        assign ctrl_fg_offset_y[(PRECISION+1)*g +: PRECISION+1] = active[g].off_y;
        assign ctrl_fg_clip_left[PRECISION*g +: PRECISION]   = active[g].clip_left;
        assign ctrl_fg_clip_right[PRECISION*g +: PRECISION]  = active[g].clip_right;
        assign ctrl_fg_clip_top[PRECISION*g +: PRECISION]    = active[g].clip_top;
        assign ctrl_fg_clip_bottom[PRECISION*g +: PRECISION] = active[g].clip_bottom;
    end

    // ------------------------------------------------------------------
    // MISO readback
    // ------------------------------------------------------------------
`ifdef CTRL_READBACK_EN
    logic        ss_prev;
    logic        sclk_fall;
    logic        ss_fall;
    logic [2:0]  rd_layer;
    logic [3:0]  rd_reg;
    logic [15:0] rd_data;
    logic [15:0] miso_shift;

    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_fall   = ~ss_s & ss_prev;
    // After eight rising edges the low byte of the shifter holds byte 0.
    assign rd_layer  = shift_reg[6:4];
    assign rd_reg    = shift_reg[3:0];

    // Remember synchronised SS to spot the start of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_prev <= 1'b1;
        end else begin
            ss_prev <= ss_s;
        end
    end

    // Select the addressed shadow field; offsets sign-extend, others zero-extend.
    always_comb begin
        rd_data = '0;
        if (!shift_reg[7]) begin
            for (int i = 0; i < LAYER_COUNT; i++) begin
                if (int'(rd_layer) == i) begin
                    case (rd_reg)
                        4'd0: rd_data = 16'(shadow[i].mode);
                        4'd1: rd_data = 16'(shadow[i].scale);
                        4'd2: rd_data = 16'($signed(shadow[i].off_x));
                        4'd3: rd_data = 16'($signed(shadow[i].off_y));
                        4'd4: rd_data = 16'(shadow[i].clip_left);
                        4'd5: rd_data = 16'(shadow[i].clip_right);
                        4'd6: rd_data = 16'(shadow[i].clip_top);
                        4'd7: rd_data = 16'(shadow[i].clip_bottom);
                        default: rd_data = '0;
                    endcase
                end
            end
        end
    end

    // Status byte presented at SS fall, data loaded at the byte-0/1 boundary,
    // and shifted MSB first on each synchronised SCLK fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_shift <= '0;
        end else if (ss_fall) begin
            miso_shift <= {commit_pending, 15'b0};
        end else if (state == S_SHIFT && sclk_fall) begin
            if (bit_cnt == 5'd8) begin
                miso_shift <= rd_data;
            end else begin
                miso_shift <= miso_shift << 1;
            end
        end else if (ss_s) begin
            miso_shift <= '0;
        end
    end

    assign hw_spi_miso = miso_shift[15];
`else
    assign hw_spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_layered_spi_control.sv
// tb_layered_spi_control: directed self-checking bench for layered_spi_control
// with default parameters (PRECISION=11, LAYER_COUNT=2), readback disabled.
module tb_layered_spi_control;

    localparam int PRECISION   = 11;
    localparam int LAYER_COUNT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic hw_spi_clk = 1'b0;
    logic hw_spi_ss = 1'b1;
    logic hw_spi_mosi = 1'b0;
    logic hw_spi_miso;
    logic [2*LAYER_COUNT-1:0]             ctrl_overlay_mode;
    logic [2*LAYER_COUNT-1:0]             ctrl_fg_scale;
    logic [(PRECISION+1)*LAYER_COUNT-1:0] ctrl_fg_offset_x;
    logic [(PRECISION+1)*LAYER_COUNT-1:0] ctrl_fg_offset_y;
    logic [PRECISION*LAYER_COUNT-1:0]     ctrl_fg_clip_left;
    logic [PRECISION*LAYER_COUNT-1:0]     ctrl_fg_clip_right;
    logic [PRECISION*LAYER_COUNT-1:0]     ctrl_fg_clip_top;
    logic [PRECISION*LAYER_COUNT-1:0]     ctrl_fg_clip_bottom;
    logic                                 commit_done;

    int n_checks = 0;
    int n_fail   = 0;
    int commit_cnt = 0;
    int exp_commits = 0;
    bit miso_seen_high = 1'b0;

    layered_spi_control #(
        .PRECISION   (PRECISION),
        .LAYER_COUNT (LAYER_COUNT),
        .SYNC_STAGES (2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .frame_start         (frame_start),
        .hw_spi_clk          (hw_spi_clk),
        .hw_spi_ss           (hw_spi_ss),
        .hw_spi_mosi         (hw_spi_mosi),
        .hw_spi_miso         (hw_spi_miso),
        .ctrl_overlay_mode   (ctrl_overlay_mode),
        .ctrl_fg_scale       (ctrl_fg_scale),
        .ctrl_fg_offset_x    (ctrl_fg_offset_x),
        .ctrl_fg_offset_y    (ctrl_fg_offset_y),
        .ctrl_fg_clip_left   (ctrl_fg_clip_left),
        .ctrl_fg_clip_right  (ctrl_fg_clip_right),
        .ctrl_fg_clip_top    (ctrl_fg_clip_top),
        .ctrl_fg_clip_bottom (ctrl_fg_clip_bottom),
        .commit_done         (commit_done)
    );

    // 100 MHz pixel clock.
    always #5 clk = ~clk;

    // Count commit_done pulses and watch MISO, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst && commit_done) commit_cnt++;
        if (hw_spi_miso) miso_seen_high = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Send the top nbits of data MSB first (SCLK period 160 ns = 16 clk).
    // With fs_at_exec set, frame_start is pulsed in the framer's EXEC cycle.
    task automatic spi_xfer(input logic [23:0] data, input int nbits, input bit fs_at_exec);
        @(negedge clk);
        hw_spi_ss = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            hw_spi_mosi = data[23-i];
            #80;
            hw_spi_clk = 1'b1;
            if (fs_at_exec && i == nbits - 1) begin
                #30;
                frame_start = 1'b1;
                #10;
                frame_start = 1'b0;
                #40;
            end else begin
                #80;
            end
            hw_spi_clk = 1'b0;
        end
        #80;
        hw_spi_ss = 1'b1;
        #200;
    endtask

    task automatic pulse_fs();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mode",      64'(ctrl_overlay_mode),   64'h0);
        check("rst_scale",     64'(ctrl_fg_scale),       64'h0);
        check("rst_offx",      64'(ctrl_fg_offset_x),    64'h0);
        check("rst_offy",      64'(ctrl_fg_offset_y),    64'h0);
        check("rst_clip_l",    64'(ctrl_fg_clip_left),   64'h0);
        check("rst_clip_r",    64'(ctrl_fg_clip_right),  64'h0);
        check("rst_clip_t",    64'(ctrl_fg_clip_top),    64'h0);
        check("rst_clip_b",    64'(ctrl_fg_clip_bottom), 64'h0);
        check("rst_done",      64'(commit_done),         64'h0);
        check("rst_miso",      64'(hw_spi_miso),         64'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Invalid layer write, layer1 offset_x=-5, commit, frame_start.
        spi_xfer(24'hAAFFFB, 24, 1'b0);
        spi_xfer(24'h92FFFB, 24, 1'b0);
        spi_xfer(24'h8F0000, 24, 1'b0);
        check("offx_precommit", 64'(ctrl_fg_offset_x), 64'h0);
        check("done_precommit", 64'(commit_cnt), 64'(exp_commits));
        pulse_fs();
        exp_commits++;
        check("offx_commit",    64'(ctrl_fg_offset_x), 64'hFFB000);
        check("mode_after_bad", 64'(ctrl_overlay_mode), 64'h0);
        check("done_once_1",    64'(commit_cnt), 64'(exp_commits));

        // Clip writes stay in shadow until frame_start.
        spi_xfer(24'h840010, 24, 1'b0);
        spi_xfer(24'h97FFFF, 24, 1'b0);
        spi_xfer(24'h8F0000, 24, 1'b0);
        repeat (20) @(negedge clk);
        check("clipl_nofs", 64'(ctrl_fg_clip_left),   64'h0);
        check("clipb_nofs", 64'(ctrl_fg_clip_bottom), 64'h0);
        pulse_fs();
        exp_commits++;
        check("clipl_commit", 64'(ctrl_fg_clip_left),   64'h000010);
        check("clipb_trunc",  64'(ctrl_fg_clip_bottom), 64'h3FF800);
        check("done_once_2",  64'(commit_cnt), 64'(exp_commits));

        // 13-bit partial frame is dropped.
        spi_xfer(24'h800003, 13, 1'b0);
        spi_xfer(24'h8F0000, 24, 1'b0);
        pulse_fs();
        exp_commits++;
        check("mode_partial", 64'(ctrl_overlay_mode), 64'h0);
        check("done_once_3",  64'(commit_cnt), 64'(exp_commits));
        spi_xfer(24'h800002, 24, 1'b0);
        spi_xfer(24'h9000FE, 24, 1'b0);
        spi_xfer(24'h8F0000, 24, 1'b0);
        pulse_fs();
        exp_commits++;
        check("mode_full", 64'(ctrl_overlay_mode), 64'hA);
        check("done_once_4", 64'(commit_cnt), 64'(exp_commits));

        // Commit request coinciding with frame_start waits one frame.
        spi_xfer(24'h910003, 24, 1'b0);
        spi_xfer(24'h8F0000, 24, 1'b1);
        repeat (5) @(negedge clk);
        check("sync_req_nodone",  64'(commit_cnt), 64'(exp_commits));
        check("sync_req_noscale", 64'(ctrl_fg_scale), 64'h0);
        pulse_fs();
        exp_commits++;
        check("sync_req_done",  64'(commit_cnt), 64'(exp_commits));
        check("sync_req_scale", 64'(ctrl_fg_scale), 64'hC);

        // Write coinciding with a committing frame_start lands after the copy.
        spi_xfer(24'h8F0000, 24, 1'b0);
        spi_xfer(24'h810001, 24, 1'b1);
        repeat (5) @(negedge clk);
        exp_commits++;
        check("sync_wr_done",  64'(commit_cnt), 64'(exp_commits));
        check("sync_wr_old",   64'(ctrl_fg_scale), 64'hC);
        spi_xfer(24'h8F0000, 24, 1'b0);
        pulse_fs();
        exp_commits++;
        check("sync_wr_new",   64'(ctrl_fg_scale), 64'hD);

        // Commit request to an invalid layer is ignored.
        spi_xfer(24'h930123, 24, 1'b0);
        spi_xfer(24'hAF0000, 24, 1'b0);
        pulse_fs();
        check("badcommit_done", 64'(commit_cnt), 64'(exp_commits));
        check("badcommit_offy", 64'(ctrl_fg_offset_y), 64'h0);
        spi_xfer(24'h9F0000, 24, 1'b0);
        pulse_fs();
        exp_commits++;
        check("l1commit_offy", 64'(ctrl_fg_offset_y), 64'h123000);

        // wr=0 frame has no effect without readback; MISO stays low.
        spi_xfer(24'h130005, 24, 1'b0);
        spi_xfer(24'h8F0000, 24, 1'b0);
        pulse_fs();
        exp_commits++;
        check("read_noeffect", 64'(ctrl_fg_offset_y), 64'h123000);
        check("offx_final",    64'(ctrl_fg_offset_x), 64'hFFB000);
        pulse_fs();
        check("idle_fs_done",  64'(commit_cnt), 64'(exp_commits));
        check("miso_low",      64'(miso_seen_high), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
